// File: rtl/multiplier_128b_version14_if.sv
// Operand/result bundle for the 128x128 pipelined multiplier.
//   in_valid : operand pair A/B valid this cycle (producer -> multiplier)
//   A, B     : 128-bit operands
//   out_valid: product valid this cycle (multiplier -> consumer)
//   product  : 256-bit full-width product
// master = producer/consumer side, slave = multiplier side.
interface multiplier_128b_version14_if;
  logic         in_valid;
  logic [127:0] A;
  logic [127:0] B;
  logic         out_valid;
  logic [255:0] product;

  modport master (output in_valid, A, B, input  out_valid, product);
  modport slave  (input  in_valid, A, B, output out_valid, product);
endinterface

// File: rtl/multiplier_128b_version14.sv
// Pipelined 128x128 -> 256-bit multiplier, one operand pair per clock,
// three register stages (operands, column sums, product).
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears every pipeline register
//   bus : multiplier_128b_version14_if.slave
//         in_valid/A/B in, out_valid/product out
//
// Parameters:
//   LIMB_W  : limb width of the partial-product decomposition, must divide 128
//   LATENCY : register stages from input to output (informational, keep at 3)
//
// Build option:
//   MULT128_SIGNED_EN : when defined, A/B/product are two's complement.
//                       The unsigned limb product is corrected by subtracting
//                       (A<0 ? B : 0)<<128 and (B<0 ? A : 0)<<128 modulo 2^256.

// One limb multiplier: LIMB_W x LIMB_W -> 2*LIMB_W, unsigned.
module multiplier_128b_version14_pp #(
  parameter int LIMB_W = 32
) (
  input  logic [LIMB_W-1:0]   a,
  input  logic [LIMB_W-1:0]   b,
  output logic [2*LIMB_W-1:0] p
);
  // Zero-extend first so the multiply is evaluated at full product width.
  assign p = {{LIMB_W{1'b0}}, a} * {{LIMB_W{1'b0}}, b};
endmodule

module multiplier_128b_version14 #(
  parameter int LIMB_W  = 32,
  parameter int LATENCY = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  multiplier_128b_version14_if.slave   bus
);
  localparam int W      = 128;
  localparam int PROD_W = 2 * W;
  localparam int N      = W / LIMB_W;        // limbs per operand
  localparam int NCOL   = 2 * N - 1;         // distinct weights i+j
  localparam int PP_W   = 2 * LIMB_W;
  // Up to N partial products share one column; one spare bit of headroom.
  localparam int COL_W  = PP_W + $clog2(N) + 1;
  localparam int STAGES = LATENCY;

  // valid shift register, bit s = valid of the data held in stage s
  logic [STAGES:1] vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
  end

  // ---------------------------------------------------------------- stage 1
  logic [W-1:0] a_q, b_q;

  // Operands only load on valid input; idle cycles keep the datapath quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (bus.in_valid) begin
      a_q <= bus.A;
      b_q <= bus.B;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [PP_W-1:0]  pp    [N][N];
  logic [COL_W-1:0] col_d [NCOL];
  logic [COL_W-1:0] col_q [NCOL];

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      multiplier_128b_version14_pp #(.LIMB_W(LIMB_W)) u_pp (
        .a (a_q[gi*LIMB_W +: LIMB_W]),
        .b (b_q[gj*LIMB_W +: LIMB_W]),
        .p (pp[gi][gj])
      );
    end
  end

  // Column k collects every A[i]*B[j] with i+j == k (all share weight 2^(LIMB_W*k)).
  always_comb begin
    for (int k = 0; k < NCOL; k++) begin
      col_d[k] = '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (i + j == k) col_d[k] = col_d[k] + COL_W'(pp[i][j]);
        end
      end
    end
  end

`ifdef MULT128_SIGNED_EN
  // Only the low W bits of the correction survive the shift by W mod 2^256.
  logic [W-1:0] corr_d, corr_q;

  always_comb begin
    corr_d = '0;
    if (a_q[W-1]) corr_d = corr_d + b_q;
    if (b_q[W-1]) corr_d = corr_d + a_q;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCOL; k++) col_q[k] <= '0;
`ifdef MULT128_SIGNED_EN
      corr_q <= '0;
`endif
    end else if (vld_pipe[1]) begin
      for (int k = 0; k < NCOL; k++) col_q[k] <= col_d[k];
`ifdef MULT128_SIGNED_EN
      corr_q <= corr_d;
`endif
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] product_q;

  always_comb begin
    acc = '0;
    for (int k = 0; k < NCOL; k++) begin
      acc = acc + (PROD_W'(col_q[k]) << (LIMB_W * k));
    end
`ifdef MULT128_SIGNED_EN
    acc = acc - {corr_q, {W{1'b0}}};
`endif
  end

  // product holds its last value while nothing valid arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     product_q <= '0;
    else if (vld_pipe[STAGES-1]) product_q <= acc;
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.product   = product_q;

endmodule

// File: tb/tb_multiplier_128b_version14.sv
module tb_multiplier_128b_version14;
  logic clk = 1'b0;
  logic rst = 1'b1;

  multiplier_128b_version14_if bus();

  multiplier_128b_version14 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;
  logic [255:0] q[$];   // expected products, in issue order
  logic [2:0]   vh;     // in_valid seen at the last three edges

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [255:0] model(input logic [127:0] a, input logic [127:0] b);
`ifdef MULT128_SIGNED_EN
    logic signed [255:0] sa, sb;
    sa = $signed({{128{a[127]}}, a});
    sb = $signed({{128{b[127]}}, b});
    return sa * sb;
`else
    return {128'b0, a} * {128'b0, b};
`endif
  endfunction

  // Expected out_valid: in_valid delayed by three register stages.
  always @(posedge clk or posedge rst) begin
    if (rst) vh <= '0;
    else     vh <= {vh[1:0], bus.in_valid};
  end

  // Scoreboard: sample away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", {255'b0, bus.out_valid}, 256'd0);
      chk("rst_product", bus.product, 256'd0);
    end else begin
      chk("out_valid", {255'b0, bus.out_valid}, {255'b0, vh[2]});
      if (bus.out_valid) begin
        if (q.size() == 0) chk("unexpected_out", 256'd1, 256'd0);
        else chk("product", bus.product, q.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [127:0] a, input logic [127:0] b,
                       input logic [255:0] exp);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.A = a;
    bus.B = b;
    if (v) q.push_back(exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0);
  endtask

  function automatic logic [127:0] rnd128();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 7))
      0: r = '1;
      1: r = '0;
      2: r[63:0] = '1;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [127:0] a, b;
    logic [127:0] ones;
    ones = '1;
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {255'b0, bus.out_valid}, 256'd0);
    chk("reset_product", bus.product, 256'd0);
    rst = 1'b0;

    // Directed cases (operands non-negative in both builds).
    drive(1'b1, 128'h5829EC10, 128'h123BBBCF00000000, 256'd452476455797231856 << 32);
    drive(1'b1, 128'h3489BE8F00000000, 128'hFFFFFFFF, 256'h3489BE8ECB76417100000000);
    drive(1'b1, 128'h0, 128'h0123456789ABCDEF0011223344556677, 256'd0);
    drive(1'b1, 128'h1, 128'h0FEDCBA98765432100112233DEADBEEF,
          256'h0FEDCBA98765432100112233DEADBEEF);
`ifdef MULT128_SIGNED_EN
    drive(1'b1, ones, ones, 256'd1);
    drive(1'b1, ones, 128'h1, {256{1'b1}});
`else
    drive(1'b1, ones, ones, {128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 128'h1});
    drive(1'b1, 128'h1, ones, {128'h0, ones});
`endif
    idle(5);

    // Reset with three ops in flight: outputs clear at once, nothing stale later.
    drive(1'b1, 128'hDEAD, 128'hBEEF, 256'hDEAD * 256'hBEEF);
    drive(1'b1, 128'h1234, 128'h5678, 256'h1234 * 256'h5678);
    drive(1'b1, 128'h9999, 128'h7777, 256'h9999 * 256'h7777);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {255'b0, bus.out_valid}, 256'd0);
    chk("midrst_product", bus.product, 256'd0);
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    drive(1'b1, 128'h3, 128'h5, 256'd15);
    idle(5);

    // Back-to-back random traffic, then traffic with random gaps.
    for (int n = 0; n < 1000; n++) begin
      a = rnd128();
      b = rnd128();
      drive(1'b1, a, b, model(a, b));
    end
    for (int n = 0; n < 300; n++) begin
      a = rnd128();
      b = rnd128();
      if ($urandom_range(0, 3) == 0) drive(1'b0, a, b, '0);
      else drive(1'b1, a, b, model(a, b));
    end
    idle(6);
    chk("drain", 256'(q.size()), 256'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
